// File: rtl/alu_unit.sv
// Registered integer ALU for the execute stage: one operation per cycle,
// result and flags appear one clock after the operands are sampled.
module alu_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [2:0]       operator,
  output logic [WIDTH-1:0] result,
  output logic             isZero,
  output logic             overflow,
  output logic             out_valid
);

  localparam int               MSB  = WIDTH - 1;
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  function automatic logic is_zero(input logic [WIDTH-1:0] value);
    return (value == ZERO);
  endfunction

  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] result_s;
  logic             ovf_add_s;
  logic             ovf_sub_s;
  logic             lt_signed_s;
  logic             lt_unsigned_s;
  logic             ovf_s;

  assign sum_s         = op1 + op2;
  assign diff_s        = op1 + ~op2 + ONE;
  assign ovf_add_s     = (op1[MSB] == op2[MSB]) && (sum_s[MSB] != op1[MSB]);
  assign ovf_sub_s     = (op1[MSB] != op2[MSB]) && (diff_s[MSB] != op1[MSB]);
  // Differing signs decide SLT directly; with equal signs the difference cannot overflow.
  assign lt_signed_s   = (op1[MSB] != op2[MSB]) ? op1[MSB] : diff_s[MSB];
  assign lt_unsigned_s = (op1 < op2);

  // Operator decode: next result and overflow flag.
  always_comb begin
    result_s = ZERO;
    ovf_s    = 1'b0;
    case (operator)
      3'b000: result_s = op1 & op2;
      3'b001: result_s = op1 | op2;
      3'b010: begin
        result_s = sum_s;
        ovf_s    = ovf_add_s;
      end
      3'b011: result_s = op1 ^ op2;
      3'b100: result_s = ~(op1 | op2);
      3'b101: result_s = {{(WIDTH-1){1'b0}}, lt_unsigned_s};
      3'b110: begin
        result_s = diff_s;
        ovf_s    = ovf_sub_s;
      end
      3'b111: result_s = {{(WIDTH-1){1'b0}}, lt_signed_s};
      default: begin
        result_s = ZERO;
        ovf_s    = 1'b0;
      end
    endcase
  end

  // Output registers; flags follow the registered result, held while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result    <= ZERO;
      isZero    <= 1'b1;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      result    <= result_s;
      isZero    <= is_zero(result_s);
      overflow  <= ovf_s;
      out_valid <= 1'b1;
    end else begin
      result    <= result;
      isZero    <= isZero;
      overflow  <= overflow;
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: stimulus pushes the expected outputs for the
// next edge, a negedge monitor pops and compares them.
module tb_alu_unit;

  localparam int W = 32;

  typedef struct packed {
    logic         v;
    logic [W-1:0] res;
    logic         z;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] op1;
  logic [W-1:0] op2;
  logic [2:0]   operator;
  logic [W-1:0] result;
  logic         isZero;
  logic         overflow;
  logic         out_valid;

  exp_t exp_q[$];
  exp_t held;
  int   compared   = 0;
  int   mismatched = 0;

  alu_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .op1      (op1),
    .op2      (op2),
    .operator (operator),
    .result   (result),
    .isZero   (isZero),
    .overflow (overflow),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on 64-bit values.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sb, ua, ub, s, r;
    sa = $signed(a);
    sb = $signed(b);
    ua = longint'(a);
    ub = longint'(b);
    e.v  = 1'b1;
    e.ov = 1'b0;
    r    = 64'sd0;
    case (op)
      3'b000: r = ua & ub;
      3'b001: r = ua | ub;
      3'b010: begin
        r = ua + ub;
        s = sa + sb;
        e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b011: r = ua ^ ub;
      3'b100: r = ~(ua | ub);
      3'b101: r = (ua < ub) ? 64'sd1 : 64'sd0;
      3'b110: begin
        r = ua - ub;
        s = sa - sb;
        e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      default: r = (sa < sb) ? 64'sd1 : 64'sd0;
    endcase
    e.res = r[W-1:0];
    e.z   = (e.res == 32'd0);
    return e;
  endfunction

  // Drive one cycle of inputs, record what the following edge must produce.
  task automatic step(input logic rn, input logic iv, input logic [2:0] op,
                      input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    rst_n    = rn;
    in_valid = iv;
    operator = op;
    op1      = a;
    op2      = b;
    if (!rn) begin
      held = '{v: 1'b0, res: 32'd0, z: 1'b1, ov: 1'b0};
      e    = held;
    end else if (iv) begin
      e    = model(op, a, b);
      held = e;
      held.v = 1'b0;
    end else begin
      e = held;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: compare the DUT outputs after every edge against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if (out_valid !== e.v || result !== e.res || isZero !== e.z || overflow !== e.ov) begin
        mismatched++;
        $display("FAIL outputs #%0d: got v=%0b res=%h z=%0b ov=%0b, want v=%0b res=%h z=%0b ov=%0b",
                 compared, out_valid, result, isZero, overflow, e.v, e.res, e.z, e.ov);
      end
    end
  end

  initial begin
    held = '{v: 1'b0, res: 32'd0, z: 1'b1, ov: 1'b0};
    // Reset with valid random inputs present.
    step(1'b0, 1'b1, 3'($urandom_range(0, 7)), $urandom, $urandom);
    step(1'b0, 1'b1, 3'($urandom_range(0, 7)), $urandom, $urandom);
    // Directed cases.
    step(1'b1, 1'b1, 3'b001, 32'd16, 32'd16);
    step(1'b1, 1'b1, 3'b110, 32'h0000_1234, 32'h0000_1234);
    step(1'b1, 1'b1, 3'b010, 32'h7FFF_FFFF, 32'h0000_0001);
    step(1'b1, 1'b1, 3'b111, 32'hFFFF_FFFF, 32'h0000_0001);
    step(1'b1, 1'b1, 3'b101, 32'hFFFF_FFFF, 32'h0000_0001);
    step(1'b1, 1'b1, 3'b111, 32'h8000_0000, 32'h0000_0001);
    step(1'b1, 1'b1, 3'b110, 32'h8000_0000, 32'h0000_0001);
    step(1'b1, 1'b1, 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00);
    step(1'b1, 1'b1, 3'b011, 32'hF0F0_F0F0, 32'hFF00_FF00);
    step(1'b1, 1'b1, 3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00);
    step(1'b1, 1'b0, 3'b010, 32'h1111_1111, 32'h2222_2222);
    step(1'b1, 1'b0, 3'b110, 32'h0000_0005, 32'h0000_0003);
    // Valid op, then reset the next cycle with another op presented.
    step(1'b1, 1'b1, 3'b010, 32'h1234_5678, 32'h1111_1111);
    step(1'b0, 1'b1, 3'b001, 32'hDEAD_BEEF, 32'h0000_0001);
    step(1'b1, 1'b0, 3'b001, 32'hDEAD_BEEF, 32'h0000_0001);
    // Randomized traffic with idle cycles and occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 31) != 0), ($urandom_range(0, 4) != 0),
           3'($urandom_range(0, 7)), pick_operand(), pick_operand());
    end
    step(1'b1, 1'b0, 3'b000, 32'd0, 32'd0);
    @(negedge clk);
    #1;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
